// File: rtl/bmp_pkg.sv
// rtl/bmp_pkg.sv - shared constants, index-width helper and stream FSM state type
//
// Purpose : definitions shared by the bitmap slicer and its stream controllers.
// Contents: BMP_W_DEF / BMP_H_DEF default bitmap geometry,
//           idx_w()          index width of a 0..n-1 counter (clog2, minimum 1),
//           stream_state_t   per-stream FSM state (IDLE, STREAM, DONE).
package bmp_pkg;

  localparam int BMP_W_DEF = 24;
  localparam int BMP_H_DEF = 64;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_t;

endpackage

// File: rtl/bmp_stream_ctr.sv
// rtl/bmp_stream_ctr.sv - pointer, FSM and valid/ready handshake for one slicer stream
//
// Purpose : walks a pointer across DEPTH positions once per load, presenting one
//           beat per position on a valid/ready handshake.
// Params  : DEPTH    number of positions (>= 2)
//           DIR_UP   1: pointer runs 0 -> DEPTH-1, 0: DEPTH-1 -> 0
//           EXT_NEXT 1: start/next pointer and last flags come from the i_* inputs
//                    (used by the column stream's blank-column search), 0: plain step
// Ports   : clk, rst              clock, asynchronous active-high reset
//           i_load                restart the pass (wins over a coincident transfer)
//           i_ready               downstream ready
//           i_load_ptr/last/empty first pointer after a load (EXT_NEXT only)
//           i_nxt_ptr/last        pointer after a transfer (EXT_NEXT only)
//           o_ptr, o_valid, o_last, o_done  registered stream status
module bmp_stream_ctr
  import bmp_pkg::*;
#(
  parameter int  DEPTH    = BMP_W_DEF,
  parameter bit  DIR_UP   = 1'b0,
  parameter bit  EXT_NEXT = 1'b0,
  localparam int PW       = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_ready,
  input  logic [PW-1:0] i_load_ptr,
  input  logic          i_load_last,
  input  logic          i_load_empty,
  input  logic [PW-1:0] i_nxt_ptr,
  input  logic          i_nxt_last,
  output logic [PW-1:0] o_ptr,
  output logic          o_valid,
  output logic          o_last,
  output logic          o_done
);

  localparam logic [PW-1:0] P_FIRST = DIR_UP ? '0 : PW'(DEPTH - 1);
  localparam logic [PW-1:0] P_END   = DIR_UP ? PW'(DEPTH - 1) : '0;

  stream_state_t r_state;
  logic [PW-1:0] r_ptr;
  logic          r_valid;
  logic          r_last;
  logic          r_done;

  logic [PW-1:0] w_step_ptr;
  logic [PW-1:0] w_load_ptr;
  logic          w_load_last;
  logic          w_load_empty;
  logic [PW-1:0] w_nxt_ptr;
  logic          w_nxt_last;

  assign w_step_ptr   = DIR_UP ? (r_ptr + 1'b1) : (r_ptr - 1'b1);
  assign w_load_ptr   = EXT_NEXT ? i_load_ptr   : P_FIRST;
  assign w_load_last  = EXT_NEXT ? i_load_last  : (P_FIRST == P_END);
  assign w_load_empty = EXT_NEXT ? i_load_empty : 1'b0;
  assign w_nxt_ptr    = EXT_NEXT ? i_nxt_ptr    : w_step_ptr;
  // last is decided from the pointer being loaded, so it is registered alongside it
  assign w_nxt_last   = EXT_NEXT ? i_nxt_last   : (w_step_ptr == P_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_ptr <= w_load_ptr;
      if (w_load_empty) begin
        r_state <= DONE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_state <= STREAM;
        r_valid <= 1'b1;
        r_last  <= w_load_last;
        r_done  <= 1'b0;
      end
    end else begin
      case (r_state)
        STREAM: begin
          if (i_ready) begin
            if (r_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_ptr  <= w_nxt_ptr;
              r_last <= w_nxt_last;
            end
          end
        end
        default: begin
          // IDLE and DONE only leave on a load
        end
      endcase
    end
  end

  assign o_ptr   = r_ptr;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_done  = r_done;

endmodule

// File: rtl/bmp_slicer.sv
// rtl/bmp_slicer.sv - captures a bitmap and streams columns and rows to the ALU
//
// Purpose : stores a BMP_W x BMP_H bitmap on load and plays it out on three
//           independent valid/ready streams: columns BMP_W-1..0, top rows
//           BMP_H-1..0, bottom rows 0..BMP_H-1.
// Option  : BMP_SLICER_SKIP_BLANK_EN - column stream skips all-zero columns.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           load, bmp_in    capture request and bitmap (row r at bits r*BMP_W +: BMP_W)
//           alu_start       one-cycle pulse after a load
//           col_*           column stream: data (MSB = row 0), index, last, done
//           top_*, bot_*    row streams: data, last, done
module bmp_slicer
  import bmp_pkg::*;
#(
  parameter int  BMP_W = BMP_W_DEF,
  parameter int  BMP_H = BMP_H_DEF,
  localparam int CW    = idx_w(BMP_W),
  localparam int RW    = idx_w(BMP_H)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [BMP_W*BMP_H-1:0] bmp_in,
  output logic                   alu_start,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic [BMP_H-1:0]       col_data,
  output logic [CW-1:0]          col_index,
  output logic                   col_last,
  output logic                   col_done,
  output logic                   top_valid,
  input  logic                   top_ready,
  output logic [BMP_W-1:0]       top_data,
  output logic                   top_last,
  output logic                   top_done,
  output logic                   bot_valid,
  input  logic                   bot_ready,
  output logic [BMP_W-1:0]       bot_data,
  output logic                   bot_last,
  output logic                   bot_done
);

  logic [BMP_W-1:0] r_rows [BMP_H];
  logic             r_alu_start;

  logic [CW-1:0] w_col_ptr;
  logic [RW-1:0] w_top_ptr;
  logic [RW-1:0] w_bot_ptr;

  logic [CW-1:0] w_col_load_ptr;
  logic          w_col_load_last;
  logic          w_col_load_empty;
  logic [CW-1:0] w_col_nxt_ptr;
  logic          w_col_nxt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_start <= 1'b0;
      for (int r = 0; r < BMP_H; r++) r_rows[r] <= '0;
    end else begin
      r_alu_start <= load;
      if (load) begin
        for (int r = 0; r < BMP_H; r++) r_rows[r] <= bmp_in[r*BMP_W +: BMP_W];
      end
    end
  end

`ifdef BMP_SLICER_SKIP_BLANK_EN
  localparam bit COL_EXT = 1'b1;

  logic [BMP_W-1:0] w_nz_in;
  logic [BMP_W-1:0] w_nz_q;

  // OR of all rows marks the non-blank columns, for the incoming and the stored bitmap
  always_comb begin
    w_nz_in = '0;
    w_nz_q  = '0;
    for (int r = 0; r < BMP_H; r++) begin
      w_nz_in = w_nz_in | bmp_in[r*BMP_W +: BMP_W];
      w_nz_q  = w_nz_q  | r_rows[r];
    end
  end

  // highest set bit of m strictly below bound (priority search)
  function automatic logic [CW-1:0] hi_below(input logic [BMP_W-1:0] m, input int bound);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = 0; i < BMP_W; i++) begin
      if (i < bound && m[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  function automatic logic any_below(input logic [BMP_W-1:0] m, input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < BMP_W; i++) begin
      if (i < bound && m[i]) found = 1'b1;
    end
    return found;
  endfunction

  // a column is last when no non-blank column remains below it
  assign w_col_load_ptr   = hi_below(w_nz_in, BMP_W);
  assign w_col_load_empty = ~|w_nz_in;
  assign w_col_load_last  = ~any_below(w_nz_in, int'(w_col_load_ptr));
  assign w_col_nxt_ptr    = hi_below(w_nz_q, int'(w_col_ptr));
  assign w_col_nxt_last   = ~any_below(w_nz_q, int'(w_col_nxt_ptr));
`else
  localparam bit COL_EXT = 1'b0;

  assign w_col_load_ptr   = '0;
  assign w_col_load_empty = 1'b0;
  assign w_col_load_last  = 1'b0;
  assign w_col_nxt_ptr    = '0;
  assign w_col_nxt_last   = 1'b0;
`endif

  bmp_stream_ctr #(
    .DEPTH    (BMP_W),
    .DIR_UP   (1'b0),
    .EXT_NEXT (COL_EXT)
  ) u_col (
    .clk          (clk),
    .rst          (rst),
    .i_load       (load),
    .i_ready      (col_ready),
    .i_load_ptr   (w_col_load_ptr),
    .i_load_last  (w_col_load_last),
    .i_load_empty (w_col_load_empty),
    .i_nxt_ptr    (w_col_nxt_ptr),
    .i_nxt_last   (w_col_nxt_last),
    .o_ptr        (w_col_ptr),
    .o_valid      (col_valid),
    .o_last       (col_last),
    .o_done       (col_done)
  );

  bmp_stream_ctr #(
    .DEPTH    (BMP_H),
    .DIR_UP   (1'b0),
    .EXT_NEXT (1'b0)
  ) u_top (
    .clk          (clk),
    .rst          (rst),
    .i_load       (load),
    .i_ready      (top_ready),
    .i_load_ptr   ('0),
    .i_load_last  (1'b0),
    .i_load_empty (1'b0),
    .i_nxt_ptr    ('0),
    .i_nxt_last   (1'b0),
    .o_ptr        (w_top_ptr),
    .o_valid      (top_valid),
    .o_last       (top_last),
    .o_done       (top_done)
  );

  bmp_stream_ctr #(
    .DEPTH    (BMP_H),
    .DIR_UP   (1'b1),
    .EXT_NEXT (1'b0)
  ) u_bot (
    .clk          (clk),
    .rst          (rst),
    .i_load       (load),
    .i_ready      (bot_ready),
    .i_load_ptr   ('0),
    .i_load_last  (1'b0),
    .i_load_empty (1'b0),
    .i_nxt_ptr    ('0),
    .i_nxt_last   (1'b0),
    .o_ptr        (w_bot_ptr),
    .o_valid      (bot_valid),
    .o_last       (bot_last),
    .o_done       (bot_done)
  );

  // data follows the registered pointers and the stored bitmap, so it changes
  // only on the edge that moves a pointer and reads zero after reset
  always_comb begin
    col_data = '0;
    for (int r = 0; r < BMP_H; r++) col_data[BMP_H-1-r] = r_rows[r][w_col_ptr];
  end

  assign col_index = w_col_ptr;
  assign top_data  = r_rows[w_top_ptr];
  assign bot_data  = r_rows[w_bot_ptr];
  assign alu_start = r_alu_start;

endmodule

// File: tb/tb_bmp_slicer.sv
// tb/tb_bmp_slicer.sv - scoreboard testbench for bmp_slicer with a behavioural model
module tb_bmp_slicer;

  localparam int W  = 24;
  localparam int H  = 64;
  localparam int CW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [W*H-1:0] bmp_in = '0;
  logic           alu_start;
  logic           col_valid, col_ready = 1'b0, col_last, col_done;
  logic [H-1:0]   col_data;
  logic [CW-1:0]  col_index;
  logic           top_valid, top_ready = 1'b0, top_last, top_done;
  logic [W-1:0]   top_data;
  logic           bot_valid, bot_ready = 1'b0, bot_last, bot_done;
  logic [W-1:0]   bot_data;

  bmp_slicer #(.BMP_W(W), .BMP_H(H)) dut (
    .clk(clk), .rst(rst), .load(load), .bmp_in(bmp_in), .alu_start(alu_start),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .col_index(col_index), .col_last(col_last), .col_done(col_done),
    .top_valid(top_valid), .top_ready(top_ready), .top_data(top_data),
    .top_last(top_last), .top_done(top_done),
    .bot_valid(bot_valid), .bot_ready(bot_ready), .bot_data(bot_data),
    .bot_last(bot_last), .bot_done(bot_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [H-1:0] data;
    int           idx;
    bit           last;
  } beat_t;

  beat_t q_col[$];
  beat_t q_top[$];
  beat_t q_bot[$];

  int n_checks = 0;
  int n_pass   = 0;
  int col_pops = 0;
  int rdy_mode = 0;
  bit prev_load = 1'b0;

  task automatic check(input string name, input logic [H-1:0] act, input logic [H-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic extra_beat(input string name);
    n_checks++;
    $display("FAIL %s: beat presented and accepted, none expected", name);
  endtask

  // Model: the bitmap as a 2D array; each stream is the ordered list of beats one pass emits
  task automatic push_model(input logic [W*H-1:0] b);
    bit           m [H][W];
    beat_t        e;
    logic [H-1:0] d;
    q_col.delete(); q_top.delete(); q_bot.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) m[r][c] = b[r*W+c];
    for (int c = W - 1; c >= 0; c--) begin
      d = '0;
      for (int r = 0; r < H; r++) d[H-1-r] = m[r][c];
`ifdef BMP_SLICER_SKIP_BLANK_EN
      if (d == '0) continue;
`endif
      e.data = d; e.idx = c; e.last = 1'b0;
      q_col.push_back(e);
    end
    for (int k = 0; k < H; k++) begin
      d = '0;
      for (int c = 0; c < W; c++) d[c] = m[H-1-k][c];
      e.data = d; e.idx = H - 1 - k; e.last = (k == H - 1);
      q_top.push_back(e);
      d = '0;
      for (int c = 0; c < W; c++) d[c] = m[k][c];
      e.data = d; e.idx = k; e.last = (k == H - 1);
      q_bot.push_back(e);
    end
    if (q_col.size() > 0) begin
      e = q_col.pop_back(); e.last = 1'b1; q_col.push_back(e);
    end
  endtask

  function automatic logic [W*H-1:0] rand_bmp(input int blank_pct);
    logic [W*H-1:0] b;
    b = '0;
    for (int c = 0; c < W; c++) begin
      if ($urandom_range(99) >= blank_pct) begin
        for (int r = 0; r < H; r++) b[r*W+c] = 1'($urandom_range(1));
        b[$urandom_range(H-1)*W+c] = 1'b1;
      end
    end
    return b;
  endfunction

  // Monitor: a beat transfers on an edge with valid&ready unless load wins that edge
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_load = 1'b0;
      end else begin
        check("alu_start", H'(alu_start), H'(prev_load));
        if (!load) begin
          if (col_valid && col_ready) begin
            if (q_col.size() == 0) extra_beat("col_extra");
            else begin
              e = q_col.pop_front(); col_pops++;
              check("col_data", col_data, e.data);
              check("col_index", H'(col_index), H'(e.idx));
              check("col_last", H'(col_last), H'(e.last));
            end
          end
          if (top_valid && top_ready) begin
            if (q_top.size() == 0) extra_beat("top_extra");
            else begin
              e = q_top.pop_front();
              check("top_data", H'(top_data), e.data);
              check("top_last", H'(top_last), H'(e.last));
            end
          end
          if (bot_valid && bot_ready) begin
            if (q_bot.size() == 0) extra_beat("bot_extra");
            else begin
              e = q_bot.pop_front();
              check("bot_data", H'(bot_data), e.data);
              check("bot_last", H'(bot_last), H'(e.last));
            end
          end
        end
        prev_load = load;
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        col_ready = 1'b1; top_ready = 1'b1; bot_ready = 1'b1;
      end else begin
        col_ready = 1'($urandom_range(1));
        top_ready = 1'($urandom_range(1));
        bot_ready = 1'($urandom_range(1));
      end
    end
  end

  task automatic apply_load(input logic [W*H-1:0] b);
    @(posedge clk); #1;
    load = 1'b1;
    bmp_in = b;
    push_model(b);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  function automatic logic [9:0] flags();
    return {col_valid, top_valid, bot_valid, col_done, top_done, bot_done,
            col_last, top_last, bot_last, alu_start};
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q_col.size() + q_top.size() + q_bot.size()) != 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d beats outstanding, 0 required", tag,
               q_col.size() + q_top.size() + q_bot.size());
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done"}, H'({col_done, top_done, bot_done, col_valid, top_valid, bot_valid}),
          H'(6'b111000));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, finish required");
    $fatal(1);
  end

  initial begin : stimulus
    logic [W*H-1:0] b;
    int             base, n;
    int             sc [3];
    sc[0] = 20; sc[1] = 7; sc[2] = 3;

    // reset state
    @(negedge clk);
    check("rst_flags", H'(flags()), '0);
    check("rst_col_data", col_data, '0);
    check("rst_rows_idx", H'({top_data, bot_data, col_index}), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_flags", H'(flags()), '0);

    // parity bitmap, full throughput, column done exactly in cycle N+25
    b = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) b[r*W+c] = 1'((r + c) % 2);
    rdy_mode = 0;
    apply_load(b);
    repeat (24) @(negedge clk);
    check("col_done_n24", H'({col_done, col_valid}), H'(2'b01));
    @(negedge clk);
    check("col_done_n25", H'({col_done, col_valid, top_valid}), H'(3'b101));
    drain("parity");

    // random bitmaps under random backpressure, including a restart mid-stream
    rdy_mode = 1;
    for (int t = 0; t < 3; t++) begin
      apply_load(rand_bmp(30));
      drain("random");
    end
    apply_load(rand_bmp(30));
    repeat ($urandom_range(5, 40)) @(negedge clk);
    apply_load(rand_bmp(30));
    drain("restart");

    // load coincident with the 5th column transfer
    rdy_mode = 0;
    apply_load(rand_bmp(0));
    base = col_pops;
    n = 0;
    while (col_pops < base + 4 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL coincide_wait: %0d column beats seen, 4 required", col_pops - base);
    end
    apply_load(rand_bmp(20));
    drain("coincide");

    // asynchronous reset mid-stream
    rdy_mode = 1;
    apply_load(rand_bmp(10));
    repeat (6) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    q_col.delete(); q_top.delete(); q_bot.delete();
    #1;
    check("async_rst_flags", H'(flags()), '0);
    check("async_rst_col_data", col_data, '0);
    check("async_rst_rows_idx", H'({top_data, bot_data, col_index}), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_idle", H'(flags()), '0);
    end
    apply_load(rand_bmp(30));
    drain("post_rst");

    // sparse columns 20, 7, 3 and an all-zero bitmap
    b = '0;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < H; r++) b[r*W+sc[k]] = 1'($urandom_range(1));
      b[$urandom_range(H-1)*W+sc[k]] = 1'b1;
    end
    rdy_mode = 1;
    apply_load(b);
    drain("sparse");
    apply_load('0);
    drain("zero");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
